// File: rtl/uart_prog_streamer.sv
// uart_prog_streamer: fetches DATA_W-bit words from a synchronous read port and
// sends each one LSB-byte-first as UART frames on tx_o, one word per ready check.
// Optional feature macro: UART_STREAM_PARITY_EN (adds an even-parity bit, 8E1/8E2).
module uart_prog_streamer #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_CLKS     = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   word_count_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              ready_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_valid_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   words_sent_o
);

    localparam int NB   = DATA_W / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [31:0]     BIT_RELOAD  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     STOP_RELOAD = 32'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [31:0]     GAP_RELOAD  = 32'(GAP_CLKS - 1);
    localparam logic [BI_W-1:0] LAST_BYTE   = BI_W'(NB - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_RDY = 4'd1,
        ST_FETCH    = 4'd2,
        ST_START    = 4'd3,
        ST_DATA     = 4'd4,
`ifdef UART_STREAM_PARITY_EN
        ST_PARITY   = 4'd5,
`endif
        ST_STOP     = 4'd6,
        ST_GAP      = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   words_sent_q, words_sent_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rdy_meta_q, rdy_meta_d;
    logic              rdy_sync_q, rdy_sync_d;
    logic              frame_end_s;
    logic [ADDR_W:0]   words_inc_s;
    logic [7:0]        cur_byte_s;

    // Two-flop synchroniser input for the asynchronous target-ready line.
    always_comb begin
        rdy_meta_d = ready_i;
        rdy_sync_d = rdy_meta_q;
    end

    // Next-state and datapath: sequencing, bit timing down-counter, word/byte tracking.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        count_d      = count_q;
        base_d       = base_q;
        words_sent_d = words_sent_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        frame_end_s  = 1'b0;
        words_inc_s  = words_sent_q + (ADDR_W+1)'(1'b1);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d      = word_count_i;
                    base_d       = base_addr_i;
                    words_sent_d = {(ADDR_W+1){1'b0}};
                    if (word_count_i == {(ADDR_W+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_RDY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_sync_q) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = base_q + words_sent_q[ADDR_W-1:0];
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_FETCH: begin
                // Data is only taken after the strobe cycle (read latency >= 1).
                if (mem_valid_i && !mem_req_q) begin
                    word_d     = mem_rdata_i;
                    byte_idx_d = {BI_W{1'b0}};
                    cnt_d      = BIT_RELOAD;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_START: begin
                if (cnt_q == 32'd0) begin
                    cnt_d   = BIT_RELOAD;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 32'd0) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_STREAM_PARITY_EN
                        cnt_d   = BIT_RELOAD;
                        state_d = ST_PARITY;
`else
                        cnt_d   = STOP_RELOAD;
                        state_d = ST_STOP;
`endif
                    end else begin
                        cnt_d = BIT_RELOAD;
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
`ifdef UART_STREAM_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == 32'd0) begin
                    cnt_d   = STOP_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == 32'd0) begin
                    if (GAP_CLKS > 0) begin
                        cnt_d   = GAP_RELOAD;
                        state_d = ST_GAP;
                    end else begin
                        frame_end_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 32'd0) begin
                    frame_end_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of a frame: next byte of the same word, or word bookkeeping.
        if (frame_end_s) begin
            if (byte_idx_q != LAST_BYTE) begin
                byte_idx_d = byte_idx_q + BI_W'(1'b1);
                word_d     = word_q >> 4'd8;
                cnt_d      = BIT_RELOAD;
                state_d    = ST_START;
            end else begin
                words_sent_d = words_inc_s;
                if (words_inc_s == count_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
        end else begin
            byte_idx_d = byte_idx_d;
        end
    end

    // Output decode from the next state so tx/busy/done are registered and glitch-free.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        tx_d       = 1'b1;
        cur_byte_s = word_d[7:0];
        case (state_d)
            ST_IDLE:     busy_d = 1'b0;
            ST_WAIT_RDY: busy_d = 1'b1;
            ST_FETCH:    busy_d = 1'b1;
            ST_START: begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
            end
            ST_DATA: begin
                busy_d = 1'b1;
                tx_d   = cur_byte_s[bit_d];
            end
`ifdef UART_STREAM_PARITY_EN
            ST_PARITY: begin
                busy_d = 1'b1;
                tx_d   = ^cur_byte_s;
            end
`endif
            ST_STOP:     busy_d = 1'b1;
            ST_GAP:      busy_d = 1'b1;
            ST_DONE:     done_d = 1'b1;
            default:     busy_d = 1'b0;
        endcase
    end

    // State and datapath registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            bit_q        <= 3'd0;
            byte_idx_q   <= {BI_W{1'b0}};
            word_q       <= {DATA_W{1'b0}};
            count_q      <= {(ADDR_W+1){1'b0}};
            base_q       <= {ADDR_W{1'b0}};
            words_sent_q <= {(ADDR_W+1){1'b0}};
            mem_req_q    <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdy_meta_q   <= 1'b0;
            rdy_sync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            count_q      <= count_d;
            base_q       <= base_d;
            words_sent_q <= words_sent_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rdy_meta_q   <= rdy_meta_d;
            rdy_sync_q   <= rdy_sync_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_sent_o = words_sent_q;

endmodule

// File: tb/tb_uart_prog_streamer.sv
// Scoreboarded bench for uart_prog_streamer: a UART receiver and a memory
// responder check every frame and read address against queued expectations.
module tb_uart_prog_streamer;

    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int CPB = 4;
`ifdef UART_STREAM_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int NS = FRAME_BITS * CPB;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW:0]   word_count_i;
    logic [AW-1:0] base_addr_i;
    logic          ready_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_valid_i;
    logic          tx_o;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   words_sent_o;

    uart_prog_streamer #(
        .DATA_W(DW), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .GAP_CLKS(0), .STOP_BITS(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .word_count_i(word_count_i),
        .base_addr_i(base_addr_i), .ready_i(ready_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i),
        .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .words_sent_o(words_sent_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [7:0]    exp_bytes[$];
    logic [AW-1:0] exp_addr[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_cnt = 0;
    int            req_seen = 0;
    logic          smp [0:NS-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the words at base..base+cnt-1 (mod 2^AW), each sent low byte first.
    task automatic expect_xfer(input logic [AW-1:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] w;
            a = base + AW'(i);
            w = mem[a];
            exp_addr.push_back(a);
            for (int b = 0; b < DW/8; b++) exp_bytes.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input int cnt);
        expect_xfer(base, cnt);
        @(negedge clk);
        base_addr_i  = base;
        word_count_i = (AW+1)'(cnt);
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        base_addr_i  = $urandom;
        word_count_i = $urandom;
    endtask

    task automatic wait_done(input int budget, input bit jitter);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                hit = 1'b1;
                break;
            end
            if (jitter) begin
                if (ready_i && $urandom_range(0, 199) == 0) ready_i = 1'b0;
                else if (!ready_i && $urandom_range(0, 29) == 0) ready_i = 1'b1;
            end
        end
        ready_i = 1'b1;
        if (!hit) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_xfer(input int cnt, input int c0, input bit jitter);
        wait_done(5000, jitter);
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - c0), 64'd1);
        chk("words_sent", 64'(words_sent_o), 64'(cnt));
        chk("busy_after_done", 64'(busy_o), 64'd0);
        chk("bytes_left", 64'(exp_bytes.size()), 64'd0);
        chk("addrs_left", 64'(exp_addr.size()), 64'd0);
    endtask

    // Done pulse monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) done_cnt++;
        end
    end

    // UART receiver: samples every clock of a frame, checks exact bit timing and value.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && tx_o === 1'b0) begin
                bit         aborted;
                bit         ok;
                logic [7:0] d;
                logic [7:0] e;
                aborted = 1'b0;
                smp[0]  = 1'b0;
                for (int k = 1; k < NS; k++) begin
                    @(negedge clk);
                    smp[k] = tx_o;
                    if (rst_ni !== 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    ok = 1'b1;
                    for (int k = 0; k < CPB; k++) if (smp[k] !== 1'b0) ok = 1'b0;
                    for (int j = 0; j < FRAME_BITS - 2; j++) begin
                        if (j < 8) d[j] = smp[CPB*(1+j)];
                        for (int k = 0; k < CPB; k++)
                            if (smp[CPB*(1+j)+k] !== smp[CPB*(1+j)]) ok = 1'b0;
                    end
                    for (int k = CPB*(FRAME_BITS-1); k < NS; k++) if (smp[k] !== 1'b1) ok = 1'b0;
                    chk("frame_shape", 64'(ok), 64'd1);
                    if (exp_bytes.size() == 0) begin
                        chk("unexpected_frame", 64'(d), 64'hDEAD);
                    end else begin
                        e = exp_bytes.pop_front();
                        chk("tx_byte", 64'(d), 64'(e));
`ifdef UART_STREAM_PARITY_EN
                        chk("parity_bit", 64'(smp[CPB*9]), 64'(^e));
`endif
                    end
                end
            end
        end
    end

    // Memory responder: checks each read strobe and returns data after 1-3 cycles.
    initial begin
        mem_valid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && mem_req_o === 1'b1) begin
                logic [AW-1:0] a;
                int            lat;
                a = mem_addr_o;
                req_seen++;
                if (exp_addr.size() == 0) chk("unexpected_req", 64'(a), 64'hDEAD);
                else chk("mem_addr", 64'(a), 64'(exp_addr.pop_front()));
                lat = $urandom_range(1, 3);
                @(posedge clk);
                #1;
                chk("req_one_cycle", 64'(mem_req_o), 64'd0);
                repeat (lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                mem_valid_i = 1'b1;
                mem_rdata_i = mem[a];
                @(posedge clk);
                #1;
                mem_valid_i = 1'b0;
                mem_rdata_i = $urandom;
            end
        end
    end

    // Global time limit.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Directed scenarios followed by randomized transfers.
    initial begin
        int            c0;
        int            r0;
        int            n;
        bit            flag;
        logic [AW-1:0] b;

        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        ready_i      = 1'b1;
        word_count_i = '0;
        base_addr_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_words_sent", 64'(words_sent_o), 64'd0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);

        // Single word 0x12345678 from address 0.
        mem[0] = 32'h1234_5678;
        c0 = done_cnt;
        start_xfer(14'd0, 1);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        finish_xfer(1, c0, 1'b0);

        // Ready gating: nothing leaves until ready has passed the synchroniser.
        ready_i = 1'b0;
        c0 = done_cnt;
        start_xfer(14'd10, 1);
        flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || mem_req_o !== 1'b0) flag = 1'b0;
        end
        chk("gated_quiet", 64'(flag), 64'd1);
        ready_i = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("ready_latency_2_3", 64'(n >= 2 && n <= 3), 64'd1);
        finish_xfer(1, c0, 1'b0);

        // Per-word stall: ready drops during word 1, word 2 withheld.
        b  = AW'($urandom_range(0, 16000));
        c0 = done_cnt;
        r0 = req_seen;
        start_xfer(b, 3);
        for (int i = 0; i < 100 && req_seen == r0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        ready_i = 1'b0;
        repeat (400) @(negedge clk);
        chk("stall_reqs", 64'(req_seen - r0), 64'd1);
        chk("stall_busy", 64'(busy_o), 64'd1);
        chk("stall_words_sent", 64'(words_sent_o), 64'd1);
        ready_i = 1'b1;
        finish_xfer(3, c0, 1'b0);

        // Zero count: done the cycle after start, no fetch, no frame.
        c0 = done_cnt;
        r0 = req_seen;
        start_xfer(14'd5, 0);
        chk("zero_done_next", 64'(done_o), 64'd1);
        chk("zero_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("zero_done_once", 64'(done_o), 64'd0);
        repeat (60) @(negedge clk);
        chk("zero_no_req", 64'(req_seen - r0), 64'd0);
        chk("zero_words_sent", 64'(words_sent_o), 64'd0);

        // Address wrap: 0x3FFF then 0x0000.
        c0 = done_cnt;
        start_xfer(14'h3FFF, 2);
        finish_xfer(2, c0, 1'b0);

        // Reset during the second byte's data bits, then restart from base.
        b = AW'($urandom_range(0, 16000));
        start_xfer(b, 2);
        for (int i = 0; i < 300 && exp_bytes.size() > 7; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("midrst_tx", 64'(tx_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_words_sent", 64'(words_sent_o), 64'd0);
        exp_bytes.delete();
        exp_addr.delete();
        repeat (5) @(negedge clk);
        rst_ni = 1'b1;
        repeat (60) @(negedge clk);
        c0 = done_cnt;
        start_xfer(b, 2);
        finish_xfer(2, c0, 1'b0);

`ifdef UART_STREAM_PARITY_EN
        // Parity: 0x07 has odd weight (bit 1), 0x03 even weight (bit 0).
        mem[20] = 32'h0000_0307;
        c0 = done_cnt;
        start_xfer(14'd20, 1);
        finish_xfer(1, c0, 1'b0);
`endif

        // Randomized transfers with ready jitter and occasional wrap.
        for (int t = 0; t < 8; t++) begin
            int cnt;
            cnt = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) b = AW'(16384 - $urandom_range(1, 2));
            else b = AW'($urandom);
            c0 = done_cnt;
            start_xfer(b, cnt);
            finish_xfer(cnt, c0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
